// File: rtl/mux2_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux2_arbiter_pkg
// Purpose  : Shared encodings for the two-requester round-robin arbiter:
//            FSM state encoding and the last-served marker.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package mux2_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_A = 2'd1,
    S_GNT_B = 2'd2
  } state_t;

  // Last-served marker; the side that is NOT last wins a tie.
  localparam logic LAST_A = 1'b1;
  localparam logic LAST_B = 1'b0;

endpackage : mux2_arbiter_pkg
`default_nettype wire

// File: rtl/mux2_arbiter_mux2.sv
`default_nettype none
// ============================================================================
// Module   : mux2_arbiter_mux2
// Purpose  : Single-bit 2:1 multiplexer, the bit slice of the arbiter's
//            shared select path.
// Ports    : i_a   - input selected when i_sel = 1
//            i_b   - input selected when i_sel = 0
//            i_sel - select
//            o_y   - selected bit
// Revision : 1.0  initial release
// ============================================================================
module mux2_arbiter_mux2 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_sel,
  output logic o_y
);

  assign o_y = i_sel ? i_a : i_b;

endmodule : mux2_arbiter_mux2
`default_nettype wire

// File: rtl/mux2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux2_arbiter
// Purpose  : Round-robin arbiter sharing one registered 2:1 datapath between
//            requesters A and B, with a bounded hold time per grant.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            req_a / req_b     - level requests
//            done_a / done_b   - one-cycle release pulses (valid while granted)
//            a_data / b_data   - W-bit data words, a_valid / b_valid qualifiers
//            gnt_a / gnt_b     - registered, mutually exclusive grants
//            sel               - datapath select (1 = A), equals gnt_a
//            y_data / y_valid  - registered datapath output and qualifier
// Params   : W        - data width
//            MAX_HOLD - max consecutive grant cycles while the other side
//                       waits (>= 2)
//            CW       - hold counter width, 2**CW >= MAX_HOLD
// Revision : 1.0  initial release
// ============================================================================
module mux2_arbiter
  import mux2_arbiter_pkg::*;
#(
  parameter int W        = 8,
  parameter int MAX_HOLD = 16,
  parameter int CW       = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_a,
  input  logic         req_b,
  input  logic         done_a,
  input  logic         done_b,
  input  logic [W-1:0] a_data,
  input  logic [W-1:0] b_data,
  input  logic         a_valid,
  input  logic         b_valid,
  output logic         gnt_a,
  output logic         gnt_b,
  output logic         sel,
  output logic [W-1:0] y_data,
  output logic         y_valid
);

  state_t         r_state;
  logic           r_last;
  logic [CW-1:0]  r_hold_cnt;
  logic           r_gnt_a;
  logic           r_gnt_b;
  logic [W-1:0]   r_y_data;
  logic           r_y_valid;

  logic [W-1:0]   w_mux_y;
  logic           w_rel_a;
  logic           w_rel_b;
  logic           w_hold_max;

  // A grant is released by an explicit done pulse or by the owner
  // withdrawing its request.
  assign w_rel_a    = done_a | ~req_a;
  assign w_rel_b    = done_b | ~req_b;
  assign w_hold_max = (r_hold_cnt == CW'(MAX_HOLD - 1));

  // W-bit select path built from 1-bit mux slices; select follows gnt_a.
  for (genvar i = 0; i < W; i++) begin : g_bit
    mux2_arbiter_mux2 u_mux2 (
      .i_a   (a_data[i]),
      .i_b   (b_data[i]),
      .i_sel (r_gnt_a),
      .o_y   (w_mux_y[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_last     <= LAST_B;
      r_hold_cnt <= '0;
      r_gnt_a    <= 1'b0;
      r_gnt_b    <= 1'b0;
      r_y_data   <= '0;
      r_y_valid  <= 1'b0;
    end else begin
      // Datapath registers update every cycle, grant state or not.
      r_y_data  <= w_mux_y;
      r_y_valid <= (r_gnt_a & a_valid) | (r_gnt_b & b_valid);

      case (r_state)
        S_IDLE: begin
          // A wins when alone, or on a tie when B was served last.
          if (req_a && (!req_b || (r_last == LAST_B))) begin
            r_state    <= S_GNT_A;
            r_gnt_a    <= 1'b1;
            r_gnt_b    <= 1'b0;
            r_hold_cnt <= '0;
          end else if (req_b) begin
            r_state    <= S_GNT_B;
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b1;
            r_hold_cnt <= '0;
          end
        end

        S_GNT_A: begin
          // Release and timeout share the same exit; a timeout only
          // happens when B is waiting, so it always hands over to B.
          if (w_rel_a || (w_hold_max && req_b)) begin
            r_last     <= LAST_A;
            r_hold_cnt <= '0;
            if (req_b) begin
              r_state <= S_GNT_B;
              r_gnt_a <= 1'b0;
              r_gnt_b <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_gnt_a <= 1'b0;
              r_gnt_b <= 1'b0;
            end
          end else if (w_hold_max) begin
            // Nobody waiting: keep the grant and restart the hold window.
            r_hold_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + CW'(1);
          end
        end

        S_GNT_B: begin
          if (w_rel_b || (w_hold_max && req_a)) begin
            r_last     <= LAST_B;
            r_hold_cnt <= '0;
            if (req_a) begin
              r_state <= S_GNT_A;
              r_gnt_a <= 1'b1;
              r_gnt_b <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_gnt_a <= 1'b0;
              r_gnt_b <= 1'b0;
            end
          end else if (w_hold_max) begin
            r_hold_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + CW'(1);
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_gnt_a    <= 1'b0;
          r_gnt_b    <= 1'b0;
          r_hold_cnt <= '0;
        end
      endcase
    end
  end

  assign gnt_a   = r_gnt_a;
  assign gnt_b   = r_gnt_b;
  assign sel     = r_gnt_a;
  assign y_data  = r_y_data;
  assign y_valid = r_y_valid;

endmodule : mux2_arbiter
`default_nettype wire

// File: tb/tb_mux2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux2_arbiter
// Purpose  : Self-checking bench for mux2_arbiter. Directed stimulus pushes
//            expected output words into a queue; a monitor pops and compares
//            them whenever y_valid is presented. Grant behaviour is checked
//            directly against hand-computed values.
// Revision : 1.0  initial release
// ============================================================================
module tb_mux2_arbiter;

  localparam int W        = 8;
  localparam int MAX_HOLD = 16;
  localparam int CW       = 4;

  logic         clk;
  logic         rst_n;
  logic         req_a, req_b;
  logic         done_a, done_b;
  logic [W-1:0] a_data, b_data;
  logic         a_valid, b_valid;
  logic         gnt_a, gnt_b, sel;
  logic [W-1:0] y_data;
  logic         y_valid;

  int           n_tests;
  int           n_fail;
  logic [W-1:0] exp_q[$];
  logic         tb_done;

  mux2_arbiter #(
    .W        (W),
    .MAX_HOLD (MAX_HOLD),
    .CW       (CW)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_a   (req_a),
    .req_b   (req_b),
    .done_a  (done_a),
    .done_b  (done_b),
    .a_data  (a_data),
    .b_data  (b_data),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .sel     (sel),
    .y_data  (y_data),
    .y_valid (y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the falling edge following the next rising edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    tb_done = 1'b0;
    rst_n   = 1'b0;
    req_a   = 1'b1;
    req_b   = 1'b1;
    done_a  = 1'b0;
    done_b  = 1'b0;
    a_data  = '0;
    b_data  = '0;
    a_valid = 1'b0;
    b_valid = 1'b0;

    fork
      // Monitor: every presented word must match the oldest expectation.
      begin
        while (!tb_done) begin
          @(negedge clk);
          if (!tb_done && rst_n && y_valid) begin
            if (exp_q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_y_valid: got y_valid=1 y_data=0x%0h, expected y_valid=0 at %0t",
                       y_data, $time);
            end else begin
              chk("y_data", 32'(y_data), 32'(exp_q.pop_front()));
            end
          end
        end
      end

      // Stimulus
      begin
        // Reset state with both requesting.
        @(negedge clk);
        chk("rst_gnt_a", 32'(gnt_a), 32'd0);
        chk("rst_gnt_b", 32'(gnt_b), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_y_data", 32'(y_data), 32'd0);
        chk("rst_y_valid", 32'(y_valid), 32'd0);

        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("first_gnt_a", 32'(gnt_a), 32'd1);
        chk("first_sel", 32'(sel), 32'd1);
        chk("first_gnt_b", 32'(gnt_b), 32'd0);

        // One word through A.
        a_data  = 8'hA5;
        a_valid = 1'b1;
        exp_q.push_back(8'hA5);
        tick();
        a_valid = 1'b0;
        done_a  = 1'b1;
        tick();
        chk("handoff_gnt_b", 32'(gnt_b), 32'd1);
        chk("handoff_gnt_a", 32'(gnt_a), 32'd0);
        chk("handoff_sel", 32'(sel), 32'd0);
        done_a = 1'b0;

        // Both requesting: 16-cycle alternation starting in GNT_B.
        for (int i = 0; i < 64; i++) begin
          logic exp_a;
          if (i > 0) tick();
          exp_a = ((i / MAX_HOLD) % 2) == 1;
          chk($sformatf("alt_gnt_a[%0d]", i), 32'(gnt_a), 32'(exp_a));
          chk($sformatf("alt_gnt_b[%0d]", i), 32'(gnt_b), 32'(!exp_a));
          if (i == 0) begin
            a_data  = 8'hC3;
            b_data  = 8'h3C;
            a_valid = 1'b1;
            b_valid = 1'b1;
          end
          if (i < 63) begin
            exp_q.push_back(exp_a ? 8'hC3 : 8'h3C);
          end else begin
            a_valid = 1'b0;
            b_valid = 1'b0;
            req_b   = 1'b0;
          end
        end

        // Only A requesting, across hold-window boundaries: no switch.
        for (int i = 0; i < 40; i++) begin
          tick();
          chk($sformatf("solo_gnt_a[%0d]", i), 32'(gnt_a), 32'd1);
          chk($sformatf("solo_gnt_b[%0d]", i), 32'(gnt_b), 32'd0);
        end

        // Move to B, then drop B's request with A idle.
        req_a = 1'b0;
        req_b = 1'b1;
        tick();
        chk("to_b_gnt_b", 32'(gnt_b), 32'd1);
        chk("to_b_gnt_a", 32'(gnt_a), 32'd0);
        b_data  = 8'h5A;
        b_valid = 1'b1;
        exp_q.push_back(8'h5A);
        tick();
        req_b   = 1'b0;
        b_valid = 1'b0;
        tick();
        chk("idle_gnt_b", 32'(gnt_b), 32'd0);
        chk("idle_gnt_a", 32'(gnt_a), 32'd0);
        chk("idle_y_valid", 32'(y_valid), 32'd0);

        // Tie from IDLE after B was served last: A wins; y_data still tracks B.
        b_data = 8'h77;
        req_a  = 1'b1;
        req_b  = 1'b1;
        tick();
        chk("tie_gnt_a", 32'(gnt_a), 32'd1);
        chk("tie_gnt_b", 32'(gnt_b), 32'd0);
        chk("idle_y_data", 32'(y_data), 32'h77);
        chk("tie_y_valid", 32'(y_valid), 32'd0);

        // Reset in the middle of a B grant.
        done_a = 1'b1;
        tick();
        chk("pre_rst_gnt_b", 32'(gnt_b), 32'd1);
        done_a  = 1'b0;
        b_data  = 8'h99;
        b_valid = 1'b1;
        exp_q.push_back(8'h99);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_gnt_b", 32'(gnt_b), 32'd0);
        chk("async_rst_gnt_a", 32'(gnt_a), 32'd0);
        chk("async_rst_y_valid", 32'(y_valid), 32'd0);
        chk("async_rst_y_data", 32'(y_data), 32'd0);
        b_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_gnt_a", 32'(gnt_a), 32'd1);
        chk("post_rst_gnt_b", 32'(gnt_b), 32'd0);
        chk("post_rst_sel", 32'(sel), 32'd1);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        tb_done = 1'b1;
      end
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mux2_arbiter
`default_nettype wire
